// File: rtl/rr_select_mux_if.sv
// Handshake bundle between N producers, the selector and one shared consumer.
// The selector connects through the slave modport; the surrounding logic uses master.
interface rr_select_mux_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_ready;
    logic [NUM_CH*WIDTH-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_select_mux.sv
// N-channel registered selector: fixed (sel) or round-robin grant, one output
// register slot with valid/ready on both sides and no bubble on pop+push.
module rr_select_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic          clk,
    input  logic          rst,
    rr_select_mux_if.slave bus
);

    logic [SEL_W-1:0]  ptr_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [SEL_W-1:0]  out_ch_r;

    logic              accept_s;
    logic              fix_hit_s;
    logic              rr_hit_s;
    logic [SEL_W-1:0]  rr_ch_s;
    logic              grant_s;
    logic [SEL_W-1:0]  grant_ch_s;
    logic [WIDTH-1:0]  grant_data_s;
    logic [NUM_CH-1:0] in_ready_s;
    logic              xfer_s;

    // Channel reached k steps after p in the circular search order.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] p, input int k);
        return SEL_W'((int'(p) + k) % NUM_CH);
    endfunction

    // Fixed-mode grant: an out-of-range sel matches no channel and so never grants.
    always_comb begin
        fix_hit_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            fix_hit_s = fix_hit_s | ((bus.sel == SEL_W'(i)) && bus.in_valid[i]);
        end
    end

    // Round-robin grant: scan from farthest to nearest so the nearest valid channel after ptr wins.
    always_comb begin
        rr_hit_s = 1'b0;
        rr_ch_s  = {SEL_W{1'b0}};
        for (int k = NUM_CH; k >= 1; k--) begin
            rr_hit_s = rr_hit_s | bus.in_valid[rr_index(ptr_r, k)];
            rr_ch_s  = bus.in_valid[rr_index(ptr_r, k)] ? rr_index(ptr_r, k) : rr_ch_s;
        end
    end

    // Grant selection, ready fan-out and data mux.
    always_comb begin
        accept_s = !out_valid_r || bus.out_ready;
        if (rst) begin
            grant_s    = 1'b0;
            grant_ch_s = {SEL_W{1'b0}};
        end else if (bus.mode) begin
            grant_s    = rr_hit_s;
            grant_ch_s = rr_ch_s;
        end else begin
            grant_s    = fix_hit_s;
            grant_ch_s = bus.sel;
        end
        xfer_s       = grant_s && accept_s;
        in_ready_s   = {NUM_CH{1'b0}};
        grant_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready_s[i] = xfer_s && (grant_ch_s == SEL_W'(i));
            grant_data_s  = grant_data_s
                          | ({WIDTH{grant_ch_s == SEL_W'(i)}} & bus.in_data[i*WIDTH +: WIDTH]);
        end
    end

    // Output slot and arbitration pointer; a push overwrites a word being popped in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            ptr_r       <= SEL_W'(NUM_CH - 1);
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_ch_r    <= grant_ch_s;
            ptr_r       <= grant_ch_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;

endmodule
